cpu_issue_ctrl: RTL
===================

CPU_ISSUE_CTRL -- requirements
Module: cpu_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction-queue entries (power of two, >=4).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  in  1  discard all queued instructions (branch taken / exception).
REQ-005 SHALL have port stall  in  1  ID/EX stall request; no issue this cycle.
REQ-006 SHALL have port push_valid  in  2  per-lane fetched-instruction valid; lane 0 older.
REQ-007 SHALL have port push_inst  in  2x32  fetched instructions.
REQ-008 SHALL have port push_pc  in  2x32  fetched instruction addresses.
REQ-009 SHALL have port push_ready  out  1  queue accepts up to 2 instructions.
REQ-010 SHALL have ports issue_a_valid/issue_a_inst/issue_a_pc/issue_a_delayslot  out  1/32/32/1  older issue slot to ID stage a.
REQ-011 SHALL have ports issue_b_valid/issue_b_inst/issue_b_pc/issue_b_delayslot  out  1/32/32/1  younger issue slot to ID stage b.
REQ-012 SHALL have port count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL implement a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-014 push_ready SHALL be 1 iff count <= DEPTH-2, computed from registered count only.
REQ-015 When push_ready=1, valid lanes SHALL be written in lane order (lane 0 first); lane 1 alone is written at tail; pushes with push_ready=0 are dropped.
REQ-016 Issue outputs SHALL be combinational from head entries; dequeue occurs at the clock edge.
REQ-017 issue_a_valid SHALL be 1 iff count>=1, stall=0, flush=0, and not (head is a branch/jump and count==1).
REQ-018 Branch/jump = opcode 000010, 000011, 0001xx, 0101xx, 000001, or SPECIAL funct 001000/001001.
REQ-019 issue_b_valid SHALL be 1 iff issue_a_valid=1, count>=2, and none of: A is branch/jump; B is branch/jump; A and B both memory ops (opcode 100xxx/101xxx); either is opcode 010000 (CP0); B's rs or rt equals A's nonzero destination.
REQ-020 A's destination SHALL be rd for SPECIAL, rt for opcode 001xxx/100xxx, $31 for JAL/REGIMM-link, else none.
REQ-021 Entries dequeued per cycle SHALL equal issue_a_valid + issue_b_valid; count updates by pushes minus pops in the same cycle.
REQ-022 A registered flag ds_pending SHALL set when a branch issues in slot A and clear when the next slot-A issue occurs; issue_a_delayslot SHALL equal ds_pending; issue_b_delayslot SHALL be 0.
REQ-023 flush SHALL clear count, pointers, and ds_pending next cycle and override any same-cycle push or pop.
REQ-024 stall SHALL freeze ds_pending and dequeue while pushes continue.

Reset
REQ-025 On rst, count, pointers, ds_pending SHALL be 0; push_ready=1; all issue_*_valid=0.
REQ-026 rst mid-operation SHALL take priority over flush, push, and pop.

Configuration
REQ-027 With macro CPU_DUAL_ISSUE_EN defined, slot B SHALL follow REQ-019; undefined, issue_b_valid SHALL be constant 0 and at most one entry dequeues per cycle.

Verification
REQ-028 Push two independent ADDUs ($1<-$2+$3, $4<-$5+$6) -> next cycle both slots valid, count returns to 0.
REQ-029 Push ADDU $1<-$2+$3 then ADDU $4<-$1+$5 -> only A issues; B issues as slot A the following cycle.
REQ-030 Push BEQ alone -> no issue while count==1; push delay-slot NOP -> BEQ in A, then NOP in A with issue_a_delayslot=1.
REQ-031 Fill to DEPTH-1 with stall=1 -> push_ready=0, extra push dropped, count stays DEPTH-1; release stall -> drains two per cycle.
REQ-032 Assert flush concurrently with push of 2 and issue -> next cycle count=0, ds_pending=0, no outputs valid.
REQ-033 Build without CPU_DUAL_ISSUE_EN, push two independent instructions -> issued one per cycle over two cycles.

Source files
------------

// File: rtl/cpu_issue_ctrl.sv
// Dual-lane instruction queue with in-order issue to two ID slots (A older, B younger).
// Slot B pairing is enabled by defining CPU_DUAL_ISSUE_EN; otherwise issue is single-wide.
module cpu_issue_ctrl #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall,
    input  logic [1:0]              push_valid,
    input  logic [1:0][31:0]        push_inst,
    input  logic [1:0][31:0]        push_pc,
    output logic                    push_ready,
    output logic                    issue_a_valid,
    output logic [31:0]             issue_a_inst,
    output logic [31:0]             issue_a_pc,
    output logic                    issue_a_delayslot,
    output logic                    issue_b_valid,
    output logic [31:0]             issue_b_inst,
    output logic [31:0]             issue_b_pc,
    output logic                    issue_b_delayslot,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ds_pending;

    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [31:0]      w_a_inst;
    logic [31:0]      w_b_inst;
    logic             w_a_br;
    logic             w_b_ok;
    logic             w_wr_en;
    logic [1:0]       w_n_push;
    logic [1:0]       w_n_pop;

    // Branch/jump: J, JAL, BEQ/BNE/BLEZ/BGTZ, their likely forms, REGIMM, JR/JALR.
    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
        return (op == 6'b000010) || (op == 6'b000011) ||
               (op[5:2] == 4'b0001) || (op[5:2] == 4'b0101) ||
               (op == 6'b000001) ||
               ((op == 6'b000000) && ((funct == 6'b001000) || (funct == 6'b001001)));
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return (op[5:4] == 2'b10);
    endfunction

    function automatic logic is_cp0(input logic [5:0] op);
        return (op == 6'b010000);
    endfunction

    // Architectural destination register; 0 means no write.
    function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        if (op == 6'b000000)
            d = rd;
        else if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100))
            d = rt;
        else if ((op == 6'b000011) || ((op == 6'b000001) && rt[4]))
            d = 5'd31;
        return d;
    endfunction

    assign w_head_nxt = r_head + PTR_W'(1);
    assign w_tail_nxt = r_tail + PTR_W'(1);
    assign w_a_inst   = r_inst[r_head];
    assign w_b_inst   = r_inst[w_head_nxt];
    assign w_a_br     = is_branch(w_a_inst[31:26], w_a_inst[5:0]);

    assign push_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign count      = r_count;

    // A branch alone at the head waits for its delay slot to arrive.
    assign issue_a_valid = (r_count != CNT_W'(0)) && !stall && !flush &&
                           !(w_a_br && (r_count == CNT_W'(1)));
    assign issue_a_inst      = w_a_inst;
    assign issue_a_pc        = r_pc[r_head];
    assign issue_a_delayslot = r_ds_pending;

`ifdef CPU_DUAL_ISSUE_EN
    logic       w_b_br;
    logic       w_mem_pair;
    logic       w_cp0_any;
    logic [4:0] w_a_dst;
    logic       w_raw;

    assign w_b_br     = is_branch(w_b_inst[31:26], w_b_inst[5:0]);
    assign w_mem_pair = is_mem(w_a_inst[31:26]) && is_mem(w_b_inst[31:26]);
    assign w_cp0_any  = is_cp0(w_a_inst[31:26]) || is_cp0(w_b_inst[31:26]);
    assign w_a_dst    = dest_reg(w_a_inst[31:26], w_a_inst[20:16], w_a_inst[15:11]);
    assign w_raw      = (w_a_dst != 5'd0) &&
                        ((w_b_inst[25:21] == w_a_dst) || (w_b_inst[20:16] == w_a_dst));
    assign w_b_ok     = issue_a_valid && (r_count >= CNT_W'(2)) && !w_a_br && !w_b_br &&
                        !w_mem_pair && !w_cp0_any && !w_raw;
`else
    assign w_b_ok     = 1'b0;
`endif

    assign issue_b_valid     = w_b_ok;
    assign issue_b_inst      = w_b_inst;
    assign issue_b_pc        = r_pc[w_head_nxt];
    assign issue_b_delayslot = 1'b0;

    assign w_wr_en  = !rst && !flush && push_ready;
    assign w_n_push = push_ready ? (2'(push_valid[0]) + 2'(push_valid[1])) : 2'd0;
    assign w_n_pop  = 2'(issue_a_valid) + 2'(issue_b_valid);

    // Queue storage; a lone lane 1 lands at the tail.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (push_valid[0]) begin
                r_inst[r_tail] <= push_inst[0];
                r_pc[r_tail]   <= push_pc[0];
                if (push_valid[1]) begin
                    r_inst[w_tail_nxt] <= push_inst[1];
                    r_pc[w_tail_nxt]   <= push_pc[1];
                end
            end else if (push_valid[1]) begin
                r_inst[r_tail] <= push_inst[1];
                r_pc[r_tail]   <= push_pc[1];
            end
        end
    end

    // Pointers, occupancy and delay-slot tracking.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_ds_pending <= 1'b0;
        end else begin
            r_tail  <= r_tail + PTR_W'(w_n_push);
            r_head  <= r_head + PTR_W'(w_n_pop);
            r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_n_pop);
            if (issue_a_valid)
                r_ds_pending <= w_a_br;
        end
    end

endmodule
